// File: rtl/fuzz_vector_sequencer.sv
// Clocked stimulus sequencer comparing a golden DUT against its synthesized netlist.
// Optional macro FUZZ_SEQ_CMP_MASK_EN adds a per-bit cmp_mask input to the compare.
module fuzz_vector_sequencer #(
  parameter int IN_W    = 76,
  parameter int OUT_W   = 233,
  parameter int NUM_VEC = 21,
  parameter int SETTLE  = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [IN_W-1:0]  vec_data,
  output logic             vec_ready,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_y_a,
  input  logic [OUT_W-1:0] dut_y_b,
`ifdef FUZZ_SEQ_CMP_MASK_EN
  input  logic [OUT_W-1:0] cmp_mask,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [CNT_W-1:0] vec_idx
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SETTLE, S_CAPTURE, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IN_W-1:0]  dut_in_q, dut_in_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
  logic             ffv_q, ffv_d;
  logic [CNT_W-1:0] ffi_q, ffi_d;
  logic [CNT_W-1:0] vec_idx_q, vec_idx_d;
  logic             pass_q, pass_d;

  logic [OUT_W-1:0] diff;
  logic             mis;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
`ifdef FUZZ_SEQ_CMP_MASK_EN
    diff = (dut_y_a ^ dut_y_b) & cmp_mask;
`else
    diff = dut_y_a ^ dut_y_b;
`endif
    mis = |diff;
    // Saturate so a pathological netlist cannot wrap the count back to "pass".
    cnt_next = (mis && (mismatch_cnt_q != '1)) ? mismatch_cnt_q + CNT_W'(1) : mismatch_cnt_q;
  end

  always_comb begin
    state_d        = state_q;
    dut_in_d       = dut_in_q;
    settle_d       = settle_q;
    mismatch_cnt_d = mismatch_cnt_q;
    ffv_d          = ffv_q;
    ffi_d          = ffi_q;
    vec_idx_d      = vec_idx_q;
    pass_d         = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mismatch_cnt_d = '0;
          ffv_d          = 1'b0;
          ffi_d          = '0;
          vec_idx_d      = '0;
          pass_d         = 1'b0;
          state_d        = S_FETCH;
        end
      end
      S_FETCH: begin
        if (vec_valid) begin
          dut_in_d = vec_data;
          settle_d = SW'(SETTLE - 1);
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == '0) state_d = S_CAPTURE;
        else                settle_d = settle_q - SW'(1);
      end
      S_CAPTURE: begin
        mismatch_cnt_d = cnt_next;
        if (mis && !ffv_q) begin
          ffv_d = 1'b1;
          ffi_d = vec_idx_q;
        end
        if (vec_idx_q == CNT_W'(NUM_VEC - 1)) begin
          pass_d  = (cnt_next == '0);
          state_d = S_DONE;
        end else begin
          vec_idx_d = vec_idx_q + CNT_W'(1);
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      dut_in_q       <= '0;
      settle_q       <= '0;
      mismatch_cnt_q <= '0;
      ffv_q          <= 1'b0;
      ffi_q          <= '0;
      vec_idx_q      <= '0;
      pass_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      dut_in_q       <= dut_in_d;
      settle_q       <= settle_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      ffv_q          <= ffv_d;
      ffi_q          <= ffi_d;
      vec_idx_q      <= vec_idx_d;
      pass_q         <= pass_d;
    end
  end

  assign vec_ready        = (state_q == S_FETCH);
  assign busy             = (state_q == S_FETCH) || (state_q == S_SETTLE) || (state_q == S_CAPTURE);
  assign done             = (state_q == S_DONE);
  assign pass             = pass_q;
  assign dut_in           = dut_in_q;
  assign mismatch_cnt     = mismatch_cnt_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_idx   = ffi_q;
  assign vec_idx          = vec_idx_q;

endmodule
